sync_packet_fifo: RTL and testbench
===================================

// Module: sync_packet_fifo
// PURPOSE
// - Single-clock, parametrised packet-aware FIFO for the DAQ image path; buffers pixel bytes between
//   sensor capture and the WiFi packetiser, whose flow control is per packet rather than per word.
// - Tracks complete PKT_SIZE-word packets held, flags packet boundaries on read, and reports errors sticky.
// - Inferred dual-port RAM, no vendor IP; replaces the wrapped-IP FIFO wherever one clock suffices.
// PARAMETERS
// - DATA_WIDTH   8     word width in bits
// - ADDR_WIDTH   13    log2(depth); depth = 2**ADDR_WIDTH = 8192 words
// - PKT_SIZE     4864  words per packet; legal range 1..2**ADDR_WIDTH
// - CNT_WIDTH    4     width of pkt_count; saturates at 2**CNT_WIDTH-1
// PORTS
// - clk          in   1               single clock, rising edge
// - rst_n        in   1               asynchronous active-low reset
// - flush        in   1               synchronous clear of contents and counters
// - wr_en        in   1               write request
// - din          in   DATA_WIDTH      write data
// - full         out  1               no free location
// - rd_en        in   1               read request
// - dout         out  DATA_WIDTH      read data, registered
// - dout_valid   out  1               dout holds a word accepted the previous cycle
// - dout_sop     out  1               with dout_valid: word is first of a packet
// - dout_eop     out  1               with dout_valid: word is last of a packet
// - empty        out  1               no stored word
// - words        out  ADDR_WIDTH+1    stored-word count, 0..2**ADDR_WIDTH
// - pkt_count    out  CNT_WIDTH       complete packets stored (saturating)
// - pkt_ready    out  1               pkt_count != 0
// - overflow     out  1               sticky: write attempted while full
// - underflow    out  1               sticky: read attempted while empty
// BEHAVIOUR
// - Reset: dout=0, dout_valid=0, dout_sop=0, dout_eop=0, empty=1, full=0, words=0, pkt_count=0,
//   pkt_ready=0, overflow=0, underflow=0; write/read pointers and in-packet counters = 0. RAM not cleared.
// - Pointers ADDR_WIDTH+1 bits, wrap naturally; full = MSBs differ and lower bits equal; empty = equal.
// - Write accepted iff wr_en && !full; stored at wr_ptr, wr_ptr++. wr_en && full: dropped, overflow<=1.
// - Read accepted iff rd_en && !empty; dout<=mem[rd_ptr] next edge, rd_ptr++, dout_valid=1 for exactly
//   one cycle (latency 1). rd_en && empty: no pointer move, dout_valid=0, underflow<=1, dout holds.
// - Simultaneous accepted read+write: both occur, words unchanged; on a full FIFO only the read is
//   accepted that cycle (full evaluated before the read); on an empty FIFO only the write is accepted.
// - words, full, empty, pkt_count, pkt_ready are registered, updated the cycle after the event.
// - wr_idx: 0..PKT_SIZE-1, +1 per accepted write, wraps to 0 after PKT_SIZE-1; wrap = packet completed.
// - rd_idx: same on accepted reads; dout_sop = (rd_idx==0) at accept; dout_eop = (rd_idx==PKT_SIZE-1);
//   PKT_SIZE=1 gives sop=eop=1 on every word.
// - pkt_count: +1 on write completing a packet, -1 on read completing one; both same cycle -> unchanged;
//   increment at saturation ignored. Decrement at 0 (packet draining before it was fully written) ignored.
// - Partial packets never raise pkt_ready; reader may still drain them word by word.
// - flush (clocked, priority over wr_en/rd_en that cycle): pointers, words, idx counters, pkt_count -> 0,
//   empty=1, full=0, dout_valid=0; overflow/underflow also cleared; dout holds last value.
// - Reset mid-operation: all state returns to reset values immediately; no partial-packet memory.
// TESTING (bench with ADDR_WIDTH=4 (depth 16), PKT_SIZE=5, CNT_WIDTH=2 unless noted)
// - Write 5 words 0x01..0x05 -> pkt_count=1, pkt_ready=1 one cycle after 5th; read 5 -> dout 0x01..0x05
//   each one cycle after rd_en, sop on 0x01, eop on 0x05, pkt_count=0, empty=1.
// - Write 16 words -> full=1, words=16, pkt_count=3; 17th write -> dropped, overflow=1, words=16.
// - Full FIFO, rd_en+wr_en same cycle -> read only accepted, words=15, full=0; repeat -> both accepted.
// - Empty, rd_en -> dout_valid=0, underflow=1; then write 1 word -> empty=0 next cycle, pkt_ready=0.
// - Write 10, read 3, assert flush with wr_en=1 -> next cycle words=0, pkt_count=0, overflow=0,
//   next write lands as sop (rd_idx/wr_idx restarted).
// - PKT_SIZE=1, ADDR_WIDTH=2: write 4 -> pkt_count saturates 3; drain 4 -> sop=eop=1 each, pkt_count=0.

Source files
------------

// File: rtl/sync_packet_fifo_if.sv
// Handshake and status bundle for sync_packet_fifo; the master side drives writes, reads and flush.
interface sync_packet_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 13,
  parameter int CNT_WIDTH  = 4
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_sop;
  logic                  dout_eop;
  logic                  empty;
  logic [ADDR_WIDTH:0]   words;
  logic [CNT_WIDTH-1:0]  pkt_count;
  logic                  pkt_ready;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, din, rd_en,
    input  full, dout, dout_valid, dout_sop, dout_eop, empty, words,
           pkt_count, pkt_ready, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, din, rd_en,
    output full, dout, dout_valid, dout_sop, dout_eop, empty, words,
           pkt_count, pkt_ready, overflow, underflow
  );
endinterface

// File: rtl/sync_packet_fifo.sv
// Single-clock packet-aware FIFO: counts complete PKT_SIZE-word packets, tags sop/eop on read,
// and keeps sticky overflow/underflow flags.
module sync_packet_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 13,
  parameter int PKT_SIZE   = 4864,
  parameter int CNT_WIDTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sync_packet_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int IW    = ADDR_WIDTH + 1;
  localparam logic [IW-1:0] PKT_LAST = IW'(PKT_SIZE - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, words_q, words_d;
  logic [IW-1:0]         wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [CNT_WIDTH-1:0]  pkt_q, pkt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic full_q, full_d, empty_q, empty_d, pkt_ready_q, pkt_ready_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic dvalid_q, dvalid_d, sop_q, sop_d, eop_q, eop_d;
  logic wr_acc, rd_acc, wr_wrap, rd_wrap;

  // full/empty are the registered view, so a read on a full FIFO cannot free room for a same-cycle write
  assign wr_acc  = bus.wr_en && !full_q  && !bus.flush;
  assign rd_acc  = bus.rd_en && !empty_q && !bus.flush;
  assign wr_wrap = wr_acc && (wr_idx_q == PKT_LAST);
  assign rd_wrap = rd_acc && (rd_idx_q == PKT_LAST);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    pkt_d    = pkt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      wr_idx_d = '0;
      rd_idx_d = '0;
      pkt_d    = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (bus.wr_en && full_q)  ovf_d = 1'b1;
      if (bus.rd_en && empty_q) unf_d = 1'b1;
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        wr_idx_d = wr_wrap ? '0 : wr_idx_q + IW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        rd_idx_d = rd_wrap ? '0 : rd_idx_q + IW'(1);
        dout_d   = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        dvalid_d = 1'b1;
        sop_d    = (rd_idx_q == '0);
        eop_d    = (rd_idx_q == PKT_LAST);
      end
      // A read can complete a packet that was never counted (drained while partial), hence the 0 guard
      if (wr_wrap && !rd_wrap && pkt_q != '1)      pkt_d = pkt_q + CNT_WIDTH'(1);
      else if (rd_wrap && !wr_wrap && pkt_q != '0) pkt_d = pkt_q - CNT_WIDTH'(1);
    end
    words_d     = wr_ptr_d - rd_ptr_d;
    empty_d     = (wr_ptr_d == rd_ptr_d);
    full_d      = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                  (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
    pkt_ready_d = (pkt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      words_q     <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      pkt_q       <= '0;
      dout_q      <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      pkt_ready_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      dvalid_q    <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      words_q     <= words_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      pkt_q       <= pkt_d;
      dout_q      <= dout_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      pkt_ready_q <= pkt_ready_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      dvalid_q    <= dvalid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
    end
  end

  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.words      = words_q;
  assign bus.pkt_count  = pkt_q;
  assign bus.pkt_ready  = pkt_ready_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dvalid_q;
  assign bus.dout_sop   = sop_q;
  assign bus.dout_eop   = eop_q;
endmodule

// File: tb/tb_sync_packet_fifo.sv
// Bench for sync_packet_fifo: depth-16/PKT 5 instance under a table plus scoreboard,
// and a depth-4/PKT 1 instance for saturation and single-word packets.
module tb_sync_packet_fifo;
  localparam int DW = 8, AW = 4, PK = 5, CW = 2, DEPTH = 16;
  localparam int AW_B = 2, PK_B = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_packet_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),   .CNT_WIDTH(CW)) a ();
  sync_packet_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_B), .CNT_WIDTH(CW)) b ();

  sync_packet_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PKT_SIZE(PK), .CNT_WIDTH(CW))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  sync_packet_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_B), .PKT_SIZE(PK_B), .CNT_WIDTH(CW))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    bit         sop;
    bit         eop;
  } exp_t;

  exp_t store[$];  // contents model of dut_a
  exp_t expq[$];   // words expected on dout
  int   widx = 0;

  typedef struct {
    bit wr; logic [7:0] d; bit rd; bit fl;
    int w; int p; bit f; bit e; bit o; bit u;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [7:0] d, bit rd, bit fl,
                              int w, int p, bit f, bit e, bit o, bit u);
    vec_t v;
    v.wr = wr; v.d = d; v.rd = rd; v.fl = fl;
    v.w = w; v.p = p; v.f = f; v.e = e; v.o = o; v.u = u;
    return v;
  endfunction

  // One cycle on dut_a: model predicts acceptance from its own occupancy, then dout is scored
  task automatic step_a(bit wr, logic [7:0] d, bit rd, bit fl);
    bit   wr_ok, rd_ok;
    exp_t e;
    a.wr_en = wr; a.din = d; a.rd_en = rd; a.flush = fl;
    wr_ok = !fl && wr && (store.size() < DEPTH);
    rd_ok = !fl && rd && (store.size() > 0);
    if (fl) begin
      store.delete();
      widx = 0;
    end
    if (rd_ok) expq.push_back(store.pop_front());
    if (wr_ok) begin
      e.d = d; e.sop = (widx == 0); e.eop = (widx == PK - 1);
      store.push_back(e);
      widx = (widx + 1) % PK;
    end
    @(posedge clk); #1;
    a.wr_en = 1'b0; a.rd_en = 1'b0; a.flush = 1'b0;
    chk("dout_valid", a.dout_valid, expq.size() != 0);
    if (expq.size() != 0) begin
      e = expq.pop_front();
      if (a.dout_valid) begin
        chk("dout", a.dout, e.d);
        chk("dout_sop", a.dout_sop, e.sop);
        chk("dout_eop", a.dout_eop, e.eop);
      end
    end
  endtask

  task automatic status_a(string tag, int w, int p, bit f, bit e, bit o, bit u);
    chk({tag, ".words"},     a.words,     w);
    chk({tag, ".pkt_count"}, a.pkt_count, p);
    chk({tag, ".pkt_ready"}, a.pkt_ready, p != 0);
    chk({tag, ".full"},      a.full,      f);
    chk({tag, ".empty"},     a.empty,     e);
    chk({tag, ".overflow"},  a.overflow,  o);
    chk({tag, ".underflow"}, a.underflow, u);
  endtask

  task automatic step_b(bit wr, logic [7:0] d, bit rd);
    b.wr_en = wr; b.din = d; b.rd_en = rd; b.flush = 1'b0;
    @(posedge clk); #1;
    b.wr_en = 1'b0; b.rd_en = 1'b0;
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = mk(1, 8'h01, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 8'h02, 0, 0, 2, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 8'h03, 0, 0, 3, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 8'h04, 0, 0, 4, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 8'h05, 0, 0, 5, 1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 8'h00, 1, 0, 4, 1, 0, 0, 0, 0);
    tbl[6]  = mk(0, 8'h00, 1, 0, 3, 1, 0, 0, 0, 0);
    tbl[7]  = mk(0, 8'h00, 1, 0, 2, 1, 0, 0, 0, 0);
    tbl[8]  = mk(0, 8'h00, 1, 0, 1, 1, 0, 0, 0, 0);
    tbl[9]  = mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[10] = mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1);  // read while empty
    tbl[11] = mk(1, 8'hA0, 0, 0, 1, 0, 0, 0, 0, 1);  // partial packet: not ready
    tbl[12] = mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1);

    a.flush = 0; a.wr_en = 0; a.rd_en = 0; a.din = '0;
    b.flush = 0; b.wr_en = 0; b.rd_en = 0; b.din = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    status_a("reset", 0, 0, 0, 1, 0, 0);
    chk("reset.dout", a.dout, 0);
    chk("reset.dout_valid", a.dout_valid, 0);
    chk("reset.dout_sop", a.dout_sop, 0);
    chk("reset.dout_eop", a.dout_eop, 0);

    for (int i = 0; i < 13; i++) begin
      step_a(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].fl);
      status_a($sformatf("vec%0d", i), tbl[i].w, tbl[i].p, tbl[i].f, tbl[i].e, tbl[i].o, tbl[i].u);
    end

    step_a(0, 8'h00, 0, 1);
    status_a("flush1", 0, 0, 0, 1, 0, 0);

    // Fill to full, then overflow and simultaneous read/write on a full FIFO
    for (int i = 0; i < 16; i++) step_a(1, 8'h10 + 8'(i), 0, 0);
    status_a("fill16", 16, 3, 1, 0, 0, 0);
    step_a(1, 8'hEE, 0, 0);
    status_a("ovf", 16, 3, 1, 0, 1, 0);
    step_a(1, 8'hE1, 1, 0);
    status_a("full_rw", 15, 3, 0, 0, 1, 0);
    step_a(1, 8'hE2, 1, 0);
    status_a("rw_both", 15, 3, 0, 0, 1, 0);
    for (int i = 0; i < 15; i++) step_a(0, 8'h00, 1, 0);
    status_a("drain", 0, 0, 0, 1, 1, 0);

    // Indices are mid-packet (17 words each way), so the first 3 reads complete a packet
    for (int i = 0; i < 10; i++) step_a(1, 8'h30 + 8'(i), 0, 0);
    status_a("w10", 10, 2, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step_a(0, 8'h00, 1, 0);
    status_a("r3", 7, 1, 0, 0, 1, 0);
    step_a(1, 8'h99, 0, 1);
    status_a("flush_wr", 0, 0, 0, 1, 0, 0);
    step_a(1, 8'h77, 0, 0);
    status_a("post_flush_w", 1, 0, 0, 0, 0, 0);
    step_a(0, 8'h00, 1, 0);
    chk("post_flush_sop", a.dout_sop, 1);
    chk("post_flush_dout", a.dout, 8'h77);

    // PKT_SIZE=1: every word is a packet; count saturates at 3
    for (int i = 0; i < 4; i++) step_b(1, 8'hB0 + 8'(i), 0);
    chk("b.pkt_count_sat", b.pkt_count, 3);
    chk("b.pkt_ready", b.pkt_ready, 1);
    chk("b.full", b.full, 1);
    chk("b.words", b.words, 4);
    for (int i = 0; i < 4; i++) begin
      step_b(0, 8'h00, 1);
      chk($sformatf("b.valid%0d", i), b.dout_valid, 1);
      chk($sformatf("b.dout%0d", i), b.dout, 8'hB0 + 8'(i));
      chk($sformatf("b.sop%0d", i), b.dout_sop, 1);
      chk($sformatf("b.eop%0d", i), b.dout_eop, 1);
    end
    chk("b.pkt_count_end", b.pkt_count, 0);
    chk("b.empty_end", b.empty, 1);

    // Asynchronous reset mid-operation
    step_a(1, 8'h41, 0, 0);
    step_a(1, 8'h42, 0, 0);
    chk("pre_rst.words", a.words, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.words", a.words, 0);
    chk("async_rst.empty", a.empty, 1);
    chk("async_rst.dout", a.dout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
